// File: rtl/alu_flags_wb.sv
// Post-ALU stage: holds the NZCV status register, evaluates condition codes at accept,
// and queues results in a 2-entry in-order buffer toward write-back.
module alu_flags_wb #(
    parameter int N  = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_result,
    input  logic          in_negative,
    input  logic          in_zero,
    input  logic          in_carry,
    input  logic          in_overflow,
    input  logic          in_setflags,
    input  logic [3:0]    in_cond,
    input  logic [RW-1:0] in_rd,
    input  logic          in_regwrite,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          out_cond_pass,
    output logic [3:0]    nzcv,
    output logic [CW-1:0] retired_cnt,
    output logic [CW-1:0] squashed_cnt
);

    logic [1:0]    count_q, count_d;
    logic          inReady_q, outValid_q;
    logic [N-1:0]  res0_q, res1_q;
    logic [RW-1:0] rd0_q, rd1_q;
    logic          we0_q, we1_q;
    logic          cp0_q, cp1_q;
    logic [3:0]    nzcv_q;
    logic [CW-1:0] retired_q, squashed_q;

    logic accept, pop, condPass, newWe;
    logic flagN, flagZ, flagC, flagV;

    assign accept = in_valid & inReady_q;
    assign pop    = outValid_q & out_ready;
    assign newWe  = in_regwrite & condPass;
    assign {flagN, flagZ, flagC, flagV} = nzcv_q;

    always_comb begin
        condPass = 1'b0;
        case (in_cond)
            4'h0: condPass = flagZ;
            4'h1: condPass = ~flagZ;
            4'h2: condPass = flagC;
            4'h3: condPass = ~flagC;
            4'h4: condPass = flagN;
            4'h5: condPass = ~flagN;
            4'h6: condPass = flagV;
            4'h7: condPass = ~flagV;
            4'h8: condPass = flagC & ~flagZ;
            4'h9: condPass = ~flagC | flagZ;
            4'hA: condPass = (flagN == flagV);
            4'hB: condPass = (flagN != flagV);
            4'hC: condPass = ~flagZ & (flagN == flagV);
            4'hD: condPass = flagZ | (flagN != flagV);
            4'hE: condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!accept && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Slot 0 is always the head, so outputs come straight from its registers; empty slots hold zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= 2'd0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            res0_q     <= '0;
            res1_q     <= '0;
            rd0_q      <= '0;
            rd1_q      <= '0;
            we0_q      <= 1'b0;
            we1_q      <= 1'b0;
            cp0_q      <= 1'b0;
            cp1_q      <= 1'b0;
            nzcv_q     <= 4'b0000;
            retired_q  <= '0;
            squashed_q <= '0;
        end else begin
            count_q    <= count_d;
            inReady_q  <= (count_d != 2'd2);
            outValid_q <= (count_d != 2'd0);

            if (pop && !accept) begin
                if (count_q == 2'd2) begin
                    res0_q <= res1_q;
                    rd0_q  <= rd1_q;
                    we0_q  <= we1_q;
                    cp0_q  <= cp1_q;
                end else begin
                    res0_q <= '0;
                    rd0_q  <= '0;
                    we0_q  <= 1'b0;
                    cp0_q  <= 1'b0;
                end
                res1_q <= '0;
                rd1_q  <= '0;
                we1_q  <= 1'b0;
                cp1_q  <= 1'b0;
            end else if (accept && !pop) begin
                if (count_q == 2'd0) begin
                    res0_q <= in_result;
                    rd0_q  <= in_rd;
                    we0_q  <= newWe;
                    cp0_q  <= condPass;
                end else begin
                    res1_q <= in_result;
                    rd1_q  <= in_rd;
                    we1_q  <= newWe;
                    cp1_q  <= condPass;
                end
            end else if (accept && pop) begin
                res0_q <= in_result;
                rd0_q  <= in_rd;
                we0_q  <= newWe;
                cp0_q  <= condPass;
            end

            if (accept) begin
                if (condPass) begin
                    retired_q <= retired_q + CW'(1);
                end else begin
                    squashed_q <= squashed_q + CW'(1);
                end
                if (in_setflags && condPass) begin
                    nzcv_q <= {in_negative, in_zero, in_carry, in_overflow};
                end
            end
        end
    end

    assign in_ready      = inReady_q;
    assign out_valid     = outValid_q;
    assign out_result    = res0_q;
    assign out_rd        = rd0_q;
    assign out_we        = we0_q;
    assign out_cond_pass = cp0_q;
    assign nzcv          = nzcv_q;
    assign retired_cnt   = retired_q;
    assign squashed_cnt  = squashed_q;

endmodule

// File: doc/alu_flags_wb.md
Name: alu_flags_wb

Overview:
- Stage directly downstream of the ALU. It captures each ALU result with its N/Z/C/V flags and holds the architectural NZCV status register.
- It evaluates a 4-bit condition code for each instruction against NZCV and gates that instruction's register write-back.
- It decouples the ALU from write-back through a 2-entry valid/ready buffer. It keeps retired and squashed instruction counters for debug.

Parameters:
- N, 32, datapath width of the result.
- RW, 5, width of the destination register index.
- CW, 16, width of each statistics counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU stage presents an instruction.
- in_ready  output  1  stage can accept an instruction.
- in_result  input  N  ALU result.
- in_negative  input  1  N flag from the ALU.
- in_zero  input  1  Z flag from the ALU.
- in_carry  input  1  C flag from the ALU.
- in_overflow  input  1  V flag from the ALU.
- in_setflags  input  1  instruction updates NZCV.
- in_cond  input  4  condition code.
- in_rd  input  RW  destination register.
- in_regwrite  input  1  instruction writes rd.
- out_valid  output  1  entry available to write-back.
- out_ready  input  1  write-back consumes the entry.
- out_result  output  N  result of the head entry.
- out_rd  output  RW  rd of the head entry.
- out_we  output  1  in_regwrite AND cond_pass, captured at accept.
- out_cond_pass  output  1  condition outcome of the head entry.
- nzcv  output  4  status register as {N,Z,C,V}.
- retired_cnt  output  CW  count of accepted instructions with cond_pass=1.
- squashed_cnt  output  CW  count of accepted instructions with cond_pass=0.

Behaviour:
- Reset (asynchronous, immediate): buffer empty, out_valid=0, in_ready=1, nzcv=4'b0000, both counters 0.
- While buffer is empty, out_result, out_rd, out_we and out_cond_pass are 0.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer is a 2-entry in-order FIFO with occupancy count 0..2.
  - in_ready = (count != 2). out_valid = (count != 0).
  - All outputs are driven from registers.
- Latency: an instruction accepted in cycle t is visible at the head in cycle t+1 if the buffer was empty.
- Push and pop in the same cycle at count 1: the count stays 1 and the new entry becomes head next cycle.
- At count 0, pop is impossible. At count 2, push is blocked.
- Condition evaluation happens at accept, combinationally against the current nzcv register:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F NV: 0.
- Flag update: on accept with in_setflags=1 and cond_pass=1, nzcv <= {in_negative, in_zero, in_carry, in_overflow} at that edge. Otherwise nzcv holds.
- Flags are stored exactly as the ALU delivers them; this stage does no masking.
- Back-to-back accepts: instruction k+1 sees nzcv as updated by instruction k. Updates happen in accept order, independent of pop timing.
- Squashed instructions (cond_pass=0) are still enqueued with out_we=0, so write-back sees every instruction in order.
- Counters increment on accept only, never on pop, and wrap modulo 2^CW.
- Reset asserted mid-operation discards all buffered entries and clears nzcv and the counters. No pop handshake completes in that cycle.

Test Plan:
1. Reset, then present result=32'h0000_0005, flags N0 Z0 C1 V0, setflags=1, cond=E, regwrite=1, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_we=1, nzcv=4'b0010, retired_cnt=1.
2. Set Z=1 via an AL setflags instruction, then send cond=1 (NE), regwrite=1 -> out_we=0, out_cond_pass=0, squashed_cnt=1, nzcv unchanged at 4'b0100.
3. Hold out_ready=0 and offer 3 instructions on consecutive cycles -> first two accepted, in_ready=0 on the third. Raise out_ready -> entries pop in order, then the third is accepted.
4. Back-to-back: instruction A (AL, setflags, N=1 V=0), then B with cond=B (LT) in the next cycle -> B sees N!=V, cond_pass=1, out_we=1.
5. Conditional setflags: cond=0 (EQ) with Z=0 in nzcv and setflags=1, flags 4'b1111 -> nzcv stays at its prior value.
6. Fill the buffer to count 2, assert reset between clock edges -> out_valid=0, in_ready=1, nzcv=0 and counters=0 immediately, without waiting for a clock edge.
